// File: rtl/fb_draw_writer.sv
// fb_draw_writer: turns a stream of (x, y, color) pixels into framebuffer
// write strobes. Supports a full-screen clear; pixels arriving during the
// clear are buffered in a small FIFO and drained in arrival order afterwards.
`timescale 1ns/1ps
module fb_draw_writer #(
    parameter int unsigned FB_WIDTH   = 160,
    parameter int unsigned FB_HEIGHT  = 120,
    parameter int unsigned COLOR_BITS = 9,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           draw_x,
    input  logic [31:0]           draw_y,
    input  logic [31:0]           draw_color,
    input  logic                  draw_en,
    input  logic                  clear_req,
    input  logic [COLOR_BITS-1:0] clear_color,
    output logic [15:0]           fb_wr_addr,
    output logic [COLOR_BITS-1:0] fb_wr_data,
    output logic                  fb_wr_en,
    output logic                  busy,
    output logic                  overflow
);

    localparam int unsigned   PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0]   LAST_ADDR = 16'(FB_WIDTH * FB_HEIGHT - 1);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [15:0]           clear_cnt;
    logic [COLOR_BITS-1:0] clear_col_q;

    logic [15:0]           fifo_addr [FIFO_DEPTH];
    logic [COLOR_BITS-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic [PTR_W:0]        count_next;

    logic                  push_req;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // ---- stage p0: qualify the incoming pixel and form its address ----
    logic                  vld_p0;
    logic [15:0]           pix_addr_p0;
    logic [COLOR_BITS-1:0] pix_color_p0;
    logic                  unused_color_bits;

    // The range test uses the full 32-bit coordinates so huge values never alias
    // into the screen; the address itself only needs the low 16 bits.
    assign vld_p0       = draw_en && (draw_x < FB_WIDTH) && (draw_y < FB_HEIGHT);
    assign pix_addr_p0  = (draw_y[15:0] << 7) + (draw_y[15:0] << 5) + draw_x[15:0];
    assign pix_color_p0 = draw_color[COLOR_BITS-1:0];
    assign unused_color_bits = ^draw_color[31:COLOR_BITS];

    // FIFO bookkeeping: buffer every accepted pixel while busy (or while a clear
    // is being accepted); in DRAIN a pop every cycle frees the slot being filled.
    always_comb begin
        pop        = (state == DRAIN);
        push_req   = vld_p0 && ((state != IDLE) || clear_req);
        push       = push_req && ((count != FULL_CNT) || pop);
        drop       = push_req && !push;
        count_next = count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end

    // FIFO storage is pure data and needs no reset; pointers guard validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= pix_addr_p0;
            fifo_data[wr_ptr] <= pix_color_p0;
        end
    end

    // ---- stage p1: registered control and framebuffer write port ----
    // Sequencer: direct writes in IDLE, address sweep in CLEAR, FIFO pops in DRAIN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            clear_cnt   <= '0;
            clear_col_q <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            fb_wr_addr  <= '0;
            fb_wr_data  <= '0;
            fb_wr_en    <= 1'b0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            if (drop) overflow <= 1'b1;
            fb_wr_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (clear_req) begin
                        clear_col_q <= clear_color;
                        clear_cnt   <= '0;
                        state       <= CLEAR;
                        busy        <= 1'b1;
                    end else if (vld_p0) begin
                        fb_wr_en   <= 1'b1;
                        fb_wr_addr <= pix_addr_p0;
                        fb_wr_data <= pix_color_p0;
                    end
                end
                CLEAR: begin
                    fb_wr_en   <= 1'b1;
                    fb_wr_addr <= clear_cnt;
                    fb_wr_data <= clear_col_q;
                    if (clear_cnt == LAST_ADDR) begin
                        clear_cnt <= '0;
                        if (count_next != '0) begin
                            state <= DRAIN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        clear_cnt <= clear_cnt + 16'd1;
                    end
                end
                DRAIN: begin
                    fb_wr_en   <= 1'b1;
                    fb_wr_addr <= fifo_addr[rd_ptr];
                    fb_wr_data <= fifo_data[rd_ptr];
                    if (count_next == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_draw_writer.sv
// Directed testbench for fb_draw_writer: reset values, direct draws, range
// rejection, full clear, FIFO overflow, drain under continuous load, reset abort.
`timescale 1ns/1ps
module tb_fb_draw_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] draw_x, draw_y, draw_color;
    logic        draw_en, clear_req;
    logic [8:0]  clear_color;
    logic [15:0] fb_wr_addr;
    logic [8:0]  fb_wr_data;
    logic        fb_wr_en, busy, overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fb_draw_writer dut (
        .clk        (clk),
        .reset      (reset),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .draw_color (draw_color),
        .draw_en    (draw_en),
        .clear_req  (clear_req),
        .clear_color(clear_color),
        .fb_wr_addr (fb_wr_addr),
        .fb_wr_data (fb_wr_data),
        .fb_wr_en   (fb_wr_en),
        .busy       (busy),
        .overflow   (overflow)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        draw_en = 1'b0; clear_req = 1'b0;
        draw_x = '0; draw_y = '0; draw_color = '0; clear_color = '0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs;
        reset = 1'b1;
        tick;
        tick;
        checks++; if (fb_wr_en !== 1'b0)   begin failures++; $display("FAIL reset_en: got %b want 0", fb_wr_en); end
        checks++; if (fb_wr_addr !== 16'd0) begin failures++; $display("FAIL reset_addr: got %0d want 0", fb_wr_addr); end
        checks++; if (fb_wr_data !== 9'd0)  begin failures++; $display("FAIL reset_data: got %h want 0", fb_wr_data); end
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overflow !== 1'b0)    begin failures++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_draw_basic;
        logic [31:0] xs [5] = '{32'd5, 32'd159, 32'd0, 32'd159, 32'd0};
        logic [31:0] ys [5] = '{32'd2, 32'd119, 32'd0, 32'd0, 32'd1};
        logic [31:0] cs [5] = '{32'h1FF, 32'hABCD_E055, 32'h0, 32'h123, 32'hFFFF_FE01};
        logic [15:0] ea [5] = '{16'd325, 16'd19199, 16'd0, 16'd159, 16'd160};
        logic [8:0]  ed [5] = '{9'h1FF, 9'h055, 9'h000, 9'h123, 9'h001};
        for (int i = 0; i < 5; i++) begin
            draw_en = 1'b1; draw_x = xs[i]; draw_y = ys[i]; draw_color = cs[i];
            tick;
            checks++;
            if (fb_wr_en !== 1'b1 || fb_wr_addr !== ea[i] || fb_wr_data !== ed[i]) begin
                failures++;
                $display("FAIL draw_%0d: en=%b addr=%0d data=%h, want en=1 addr=%0d data=%h",
                         i, fb_wr_en, fb_wr_addr, fb_wr_data, ea[i], ed[i]);
            end
        end
        draw_en = 1'b0;
        tick;
        checks++; if (fb_wr_en !== 1'b0) begin failures++; $display("FAIL draw_idle_en: got %b want 0", fb_wr_en); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL draw_busy: got %b want 0", busy); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] xs [4] = '{32'd160, 32'd0, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ys [4] = '{32'd0, 32'd120, 32'd0, 32'h0001_0000};
        for (int i = 0; i < 4; i++) begin
            draw_en = 1'b1; draw_x = xs[i]; draw_y = ys[i]; draw_color = 32'h1FF;
            tick;
            checks++;
            if (fb_wr_en !== 1'b0) begin
                failures++;
                $display("FAIL oor_%0d: en=%b addr=%0d, want no write", i, fb_wr_en, fb_wr_addr);
            end
        end
        draw_en = 1'b0;
        tick;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL oor_ovf: got %b want 0", overflow); end
        checks++; if (fb_wr_en !== 1'b0) begin failures++; $display("FAIL oor_after: got %b want 0", fb_wr_en); end
    endtask

    task automatic test_clear;
        int bad = 0, first = -1;
        idle_inputs;
        clear_req = 1'b1; clear_color = 9'h0A3;
        tick;
        clear_req = 1'b0; clear_color = 9'h000;
        checks++; if (busy !== 1'b1 || fb_wr_en !== 1'b0) begin failures++; $display("FAIL clear_start: busy=%b en=%b want busy=1 en=0", busy, fb_wr_en); end
        for (int i = 0; i < 19200; i++) begin
            tick;
            if (fb_wr_en !== 1'b1 || fb_wr_addr !== 16'(i) || fb_wr_data !== 9'h0A3 ||
                (i < 19199 && busy !== 1'b1)) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL clear_seq: %0d bad cycles, first at index %0d, want 0", bad, first); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_end_busy: got %b want 0", busy); end
        tick;
        checks++; if (fb_wr_en !== 1'b0) begin failures++; $display("FAIL clear_after: en=%b addr=%0d want no write", fb_wr_en, fb_wr_addr); end
    endtask

    task automatic test_clear_overflow;
        logic [15:0] exp_a [$];
        logic [8:0]  exp_d [$];
        int bad = 0, first = -1;
        idle_inputs;
        clear_req = 1'b1; clear_color = 9'h100;
        tick;
        clear_req = 1'b0;
        for (int i = 0; i < 19200; i++) begin
            if (i >= 10 && i < 16) begin
                draw_en = 1'b1; draw_x = 32'(i - 9); draw_y = 32'd3; draw_color = 32'(16 + i - 10);
                if (i < 14) begin
                    exp_a.push_back(16'(480 + i - 9));
                    exp_d.push_back(9'(16 + i - 10));
                end
            end else begin
                draw_en = 1'b0;
            end
            tick;
            if (fb_wr_en !== 1'b1 || fb_wr_addr !== 16'(i) || fb_wr_data !== 9'h100) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        draw_en = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("FAIL ovf_clear_seq: %0d bad cycles, first at %0d, want 0", bad, first); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++;
            if (fb_wr_en !== 1'b1 || fb_wr_addr !== exp_a[k] || fb_wr_data !== exp_d[k] || busy !== (k < 3)) begin
                failures++;
                $display("FAIL ovf_drain_%0d: en=%b addr=%0d data=%h busy=%b, want en=1 addr=%0d data=%h busy=%b",
                         k, fb_wr_en, fb_wr_addr, fb_wr_data, busy, exp_a[k], exp_d[k], (k < 3));
            end
        end
        tick;
        checks++; if (fb_wr_en !== 1'b0) begin failures++; $display("FAIL ovf_dropped: en=%b addr=%0d want no write", fb_wr_en, fb_wr_addr); end
    endtask

    task automatic test_back_to_back_drain;
        logic [15:0] exp_a [$];
        logic [8:0]  exp_d [$];
        int bad = 0, first = -1;
        idle_inputs;
        do_reset;
        tick;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf_reset: got %b want 0", overflow); end
        // pixel presented together with the clear request goes to the FIFO
        clear_req = 1'b1; clear_color = 9'h0F0;
        draw_en = 1'b1; draw_x = 32'd1; draw_y = 32'd1; draw_color = 32'h011;
        exp_a.push_back(16'd161); exp_d.push_back(9'h011);
        tick;
        clear_req = 1'b0; draw_en = 1'b0;
        for (int i = 0; i < 19200; i++) begin
            clear_req = (i == 50);
            clear_color = (i == 50) ? 9'h1AA : 9'h000;
            if (i >= 100 && i < 103) begin
                draw_en = 1'b1; draw_x = 32'(10 + i - 100); draw_y = 32'd50; draw_color = 32'(32 + i - 100);
                exp_a.push_back(16'(8010 + i - 100)); exp_d.push_back(9'(32 + i - 100));
            end else begin
                draw_en = 1'b0;
            end
            tick;
            if (fb_wr_en !== 1'b1 || fb_wr_addr !== 16'(i) || fb_wr_data !== 9'h0F0) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        clear_req = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("FAIL b2b_clear_seq: %0d bad cycles, first at %0d, want 0", bad, first); end
        bad = 0; first = -1;
        for (int k = 0; k < 10; k++) begin
            if (k < 6) begin
                draw_en = 1'b1; draw_x = 32'(k); draw_y = 32'd100; draw_color = 32'(48 + k);
                exp_a.push_back(16'(16000 + k)); exp_d.push_back(9'(48 + k));
            end else begin
                draw_en = 1'b0;
            end
            tick;
            if (fb_wr_en !== 1'b1 || fb_wr_addr !== exp_a[k] || fb_wr_data !== exp_d[k] || busy !== (k < 9)) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        draw_en = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("FAIL b2b_drain_order: %0d bad writes, first at %0d, want 0", bad, first); end
        tick;
        checks++; if (fb_wr_en !== 1'b0) begin failures++; $display("FAIL b2b_after: en=%b addr=%0d want no write", fb_wr_en, fb_wr_addr); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_reset_abort;
        int bad = 0, first = -1;
        idle_inputs;
        clear_req = 1'b1; clear_color = 9'h0C3;
        tick;
        clear_req = 1'b0;
        for (int i = 0; i <= 5000; i++) begin
            if (i == 10 || i == 11) begin
                draw_en = 1'b1; draw_x = 32'd20; draw_y = 32'd20; draw_color = 32'h1;
            end else begin
                draw_en = 1'b0;
            end
            tick;
            if (fb_wr_en !== 1'b1 || fb_wr_addr !== 16'(i) || fb_wr_data !== 9'h0C3) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL abort_clear_seq: %0d bad cycles, first at %0d, want 0", bad, first); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (fb_wr_en !== 1'b0 || fb_wr_addr !== 16'd0 || fb_wr_data !== 9'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_immediate: en=%b addr=%0d data=%h busy=%b, want all 0", fb_wr_en, fb_wr_addr, fb_wr_data, busy);
        end
        tick;
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick;
            if (fb_wr_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL abort_quiet: %0d cycles with write or busy, want 0", bad); end
        draw_en = 1'b1; draw_x = 32'd7; draw_y = 32'd4; draw_color = 32'h1C2;
        tick;
        draw_en = 1'b0;
        checks++;
        if (fb_wr_en !== 1'b1 || fb_wr_addr !== 16'd647 || fb_wr_data !== 9'h1C2) begin
            failures++;
            $display("FAIL abort_draw: en=%b addr=%0d data=%h, want en=1 addr=647 data=1c2", fb_wr_en, fb_wr_addr, fb_wr_data);
        end
        tick;
        checks++; if (fb_wr_en !== 1'b0) begin failures++; $display("FAIL abort_draw_after: got %b want 0", fb_wr_en); end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs;
        test_reset;
        test_draw_basic;
        test_out_of_range;
        test_clear;
        test_clear_overflow;
        test_back_to_back_drain;
        test_reset_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_draw_writer.md
FB_DRAW_WRITER -- requirements
Module: fb_draw_writer

Interface
REQ-001 Parameter FB_WIDTH, default 160, framebuffer width in pixels.
REQ-002 Parameter FB_HEIGHT, default 120, framebuffer height in pixels.
REQ-003 Parameter COLOR_BITS, default 9, pixel color width.
REQ-004 Parameter FIFO_DEPTH, default 4, pending-draw buffer depth (power of two).
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 draw_x  input  32  pixel X from the sprite/draw producer, unsigned.
REQ-008 draw_y  input  32  pixel Y from the producer, unsigned.
REQ-009 draw_color  input  32  pixel color; only bits [COLOR_BITS-1:0] are used.
REQ-010 draw_en  input  1  pixel valid, sampled every cycle; no backpressure.
REQ-011 clear_req  input  1  single-cycle request to fill the framebuffer.
REQ-012 clear_color  input  COLOR_BITS  fill color, sampled with clear_req.
REQ-013 fb_wr_addr  output  16  framebuffer write address.
REQ-014 fb_wr_data  output  COLOR_BITS  framebuffer write data.
REQ-015 fb_wr_en  output  1  framebuffer write strobe, one write per cycle.
REQ-016 busy  output  1  high when state is not IDLE.
REQ-017 overflow  output  1  sticky; a buffered pixel was dropped.

Function
REQ-018 The block SHALL accept a pixel only when draw_en=1 and the full 32-bit values satisfy draw_x < FB_WIDTH and draw_y < FB_HEIGHT; out-of-range pixels are silently discarded, with no write and no overflow.
REQ-019 The block SHALL compute address = draw_y*160 + draw_x as (y<<7)+(y<<5)+x in 16 bits; the maximum is 19199.
REQ-020 The block SHALL have states IDLE, CLEAR and DRAIN, and SHALL reset to IDLE.
REQ-021 In IDLE, an accepted pixel SHALL produce fb_wr_en=1 with its address and color on the next cycle (1-cycle latency); with no accepted pixel, fb_wr_en=0.
REQ-022 In IDLE, clear_req=1 SHALL latch clear_color and enter CLEAR next cycle.
- A pixel accepted in the same cycle is pushed to the FIFO, not written directly.
REQ-023 In CLEAR, the block SHALL write addresses 0..FB_WIDTH*FB_HEIGHT-1 in ascending order, one per cycle, fb_wr_en=1 continuously, data = latched clear color.
REQ-024 After the last clear write (address 19199), the block SHALL go to DRAIN if the FIFO is non-empty, else to IDLE.
REQ-025 In CLEAR and DRAIN, accepted pixels SHALL be pushed to the FIFO in arrival order.
- If the FIFO is full with no pop that cycle, the pixel is dropped and overflow is set to 1.
REQ-026 In DRAIN, the block SHALL pop one FIFO entry per cycle and write it (fb_wr_en=1 the cycle after the pop decision).
- It returns to IDLE when the FIFO is empty after the pop.
REQ-027 A push and a pop in the same DRAIN cycle with the FIFO full SHALL both succeed (occupancy unchanged, no overflow).
REQ-028 While busy=1, direct writes SHALL NOT occur; all pixel writes SHALL follow FIFO order, so no pixel overtakes an earlier one.
REQ-029 clear_req while in CLEAR or DRAIN SHALL be ignored.
REQ-030 overflow SHALL be cleared only by reset.
REQ-031 busy SHALL be registered: 1 from the cycle after clear_req acceptance until the cycle IDLE is re-entered.

Reset
REQ-032 While reset=1, the block SHALL hold fb_wr_addr=0, fb_wr_data=0, fb_wr_en=0, busy=0, overflow=0, FIFO empty, clear counter 0 and state IDLE.
REQ-033 Reset asserted mid-CLEAR or mid-DRAIN SHALL abort immediately, discarding FIFO contents, with no further writes.

Verification
REQ-034 Draw (x=5,y=2,color=0x1FF) in IDLE -> next cycle fb_wr_en=1, addr=325, data=0x1FF.
REQ-035 Draw x=160,y=0 and x=0,y=120 and x=0xFFFFFFFF -> no write, overflow stays 0.
REQ-036 clear_req with clear_color=0x0A3 -> 19200 consecutive writes, addr 0..19199, data 0x0A3, busy high throughout, then IDLE.
REQ-037 6 in-range draws during CLEAR -> first 4 written in order in DRAIN right after address 19199, last 2 dropped, overflow=1.
REQ-038 Continuous draws during DRAIN with the FIFO full -> one write per cycle, order preserved, overflow unchanged.
REQ-039 Reset at clear address 5000 -> outputs zero immediately; a draw after release is written with 1-cycle latency.
